// File: rtl/expr_operand_loader.sv
// expr_operand_loader: collects eight WIDTH-bit stream words (X,Y,Z,P,Q,R,S,T)
// and presents them as one stable operand set with a valid/ready handshake.
// Optional feature: define OPLOAD_ABORT_EN to add the in_abort input port.
module expr_operand_loader #(
    parameter int unsigned WIDTH         = 32,
    parameter bit          CLR_ON_ACCEPT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
`ifdef OPLOAD_ABORT_EN
    input  logic             in_abort,
`endif
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Z,
    output logic [WIDTH-1:0] P,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] T,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [2:0]       load_cnt,
    output logic             frame_err
);

    typedef enum logic {
        LOAD = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] ops_q [8];
    logic [WIDTH-1:0] ops_d [8];
    logic             abort_w;
    logic             xfer_w;

`ifdef OPLOAD_ABORT_EN
    assign abort_w = in_abort;
`else
    assign abort_w = 1'b0;
`endif

    assign in_ready = (state_q == LOAD);
    assign xfer_w   = in_valid & in_ready;

    // State, counter, error flag and operand registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                ops_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            for (int unsigned i = 0; i < 8; i++) begin
                ops_q[i] <= ops_d[i];
            end
        end
    end

    // Next-state: accept words in LOAD, hold the set until downstream takes it
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        for (int unsigned i = 0; i < 8; i++) begin
            ops_d[i] = ops_q[i];
        end

        unique case (state_q)
            LOAD: begin
                if (abort_w) begin
                    // Abort wins over a same-cycle transfer: word dropped, no error
                    cnt_d = '0;
                end else if (xfer_w) begin
                    if (cnt_q == 3'd7) begin
                        ops_d[7] = in_data;
                        cnt_d    = '0;
                        state_d  = HOLD;
                        if (!in_last) begin
                            err_d = 1'b1;
                        end
                    end else if (in_last) begin
                        // Early in_last: drop the word and restart the set
                        err_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        ops_d[cnt_q] = in_data;
                        cnt_d        = cnt_q + 3'd1;
                    end
                end
            end
            HOLD: begin
                if (op_ready) begin
                    state_d = LOAD;
                    if (CLR_ON_ACCEPT) begin
                        for (int unsigned i = 0; i < 8; i++) begin
                            ops_d[i] = '0;
                        end
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign op_valid  = (state_q == HOLD);
    assign load_cnt  = cnt_q;
    assign frame_err = err_q;
    assign X = ops_q[0];
    assign Y = ops_q[1];
    assign Z = ops_q[2];
    assign P = ops_q[3];
    assign Q = ops_q[4];
    assign R = ops_q[5];
    assign S = ops_q[6];
    assign T = ops_q[7];

endmodule

// File: tb/tb_expr_operand_loader.sv
// Testbench for expr_operand_loader (two instances: CLR_ON_ACCEPT=0 and 1).
// Exercises in_abort when OPLOAD_ABORT_EN is defined.
module tb_expr_operand_loader;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_last = 1'b0;
    logic         in_abort = 1'b0;
    logic         op_ready = 1'b0;

    logic         in_ready, op_valid, frame_err;
    logic [2:0]   load_cnt;
    logic [W-1:0] X, Y, Z, P, Q, R, S, T;
    logic         c_in_ready, c_op_valid, c_frame_err;
    logic [2:0]   c_load_cnt;
    logic [W-1:0] cX, cY, cZ, cP, cQ, cR, cS, cT;

    always #5 clk = ~clk;

    expr_operand_loader #(.WIDTH(W), .CLR_ON_ACCEPT(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
`ifdef OPLOAD_ABORT_EN
        .in_abort(in_abort),
`endif
        .X(X), .Y(Y), .Z(Z), .P(P), .Q(Q), .R(R), .S(S), .T(T),
        .op_valid(op_valid), .op_ready(op_ready), .load_cnt(load_cnt),
        .frame_err(frame_err)
    );

    expr_operand_loader #(.WIDTH(W), .CLR_ON_ACCEPT(1'b1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data), .in_last(in_last),
`ifdef OPLOAD_ABORT_EN
        .in_abort(in_abort),
`endif
        .X(cX), .Y(cY), .Z(cZ), .P(cP), .Q(cQ), .R(cR), .S(cS), .T(cT),
        .op_valid(c_op_valid), .op_ready(op_ready), .load_cnt(c_load_cnt),
        .frame_err(c_frame_err)
    );

    logic [W-1:0] d_ops [8];
    logic [W-1:0] c_ops [8];
    assign d_ops[0] = X;  assign d_ops[1] = Y;  assign d_ops[2] = Z;  assign d_ops[3] = P;
    assign d_ops[4] = Q;  assign d_ops[5] = R;  assign d_ops[6] = S;  assign d_ops[7] = T;
    assign c_ops[0] = cX; assign c_ops[1] = cY; assign c_ops[2] = cZ; assign c_ops[3] = cP;
    assign c_ops[4] = cQ; assign c_ops[5] = cR; assign c_ops[6] = cS; assign c_ops[7] = cT;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the partial set is a queue of accepted words, a flag
    // says a full set is on offer, and two operand images (plain / clearing).
    logic [W-1:0] partial [$];
    bit           m_hold;
    bit           m_err;
    logic [W-1:0] m_ops   [8];
    logic [W-1:0] m_ops_c [8];

    task automatic mdl_reset();
        partial.delete();
        m_hold = 0;
        m_err  = 0;
        for (int i = 0; i < 8; i++) begin
            m_ops[i]   = '0;
            m_ops_c[i] = '0;
        end
    endtask

    task automatic mdl_step(input bit v, input logic [W-1:0] d, input bit l, input bit r, input bit ab);
        if (!m_hold) begin
            if (ab) begin
                partial.delete();
            end else if (v) begin
                if (partial.size() == 7) begin
                    m_ops[7]   = d;
                    m_ops_c[7] = d;
                    partial.delete();
                    m_hold = 1;
                    if (!l) m_err = 1;
                end else if (l) begin
                    m_err = 1;
                    partial.delete();
                end else begin
                    m_ops[partial.size()]   = d;
                    m_ops_c[partial.size()] = d;
                    partial.push_back(d);
                end
            end
        end else if (r) begin
            m_hold = 0;
            for (int i = 0; i < 8; i++) m_ops_c[i] = '0;
        end
    endtask

    task automatic mdl_compare();
        chk("op_valid", op_valid, m_hold);
        chk("in_ready", in_ready, !m_hold);
        chk("load_cnt", load_cnt, partial.size());
        chk("frame_err", frame_err, m_err);
        chk("c_op_valid", c_op_valid, m_hold);
        chk("c_in_ready", c_in_ready, !m_hold);
        chk("c_load_cnt", c_load_cnt, partial.size());
        chk("c_frame_err", c_frame_err, m_err);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("op%0d", i), d_ops[i], m_ops[i]);
            chk($sformatf("c_op%0d", i), c_ops[i], m_ops_c[i]);
        end
    endtask

    // Drive one cycle's inputs (called ~1ns after a rising edge), clock, then compare
    task automatic step(input bit v, input logic [W-1:0] d, input bit l, input bit r, input bit ab);
        bit ab_eff;
`ifdef OPLOAD_ABORT_EN
        ab_eff = ab;
`else
        ab_eff = 1'b0;
`endif
        in_valid = v; in_data = d; in_last = l; op_ready = r; in_abort = ab_eff;
        @(posedge clk);
        mdl_step(v, d, l, r, ab_eff);
        #1;
        mdl_compare();
    endtask

    task automatic do_reset();
        in_valid = 0; in_data = '0; in_last = 0; op_ready = 0; in_abort = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        mdl_reset();
        chk("rst_op_valid", op_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_load_cnt", load_cnt, 3'd0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_X", X, 32'd0);
        chk("rst_T", T, 32'd0);
    endtask

    typedef struct {
        bit           v;
        logic [W-1:0] d;
        bit           l;
        bit           r;
        bit           e_valid;
        bit           e_ready;
        logic [2:0]   e_cnt;
        bit           e_err;
        logic [W-1:0] e_x;
        logic [W-1:0] e_t;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(bit v, logic [W-1:0] d, bit l, bit r, bit ev, bit er,
                                logic [2:0] ec, bit ee, logic [W-1:0] ex, logic [W-1:0] et);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.r = r;
        t.e_valid = ev; t.e_ready = er; t.e_cnt = ec; t.e_err = ee; t.e_x = ex; t.e_t = et;
        return t;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Stream 1..8, hand off; early in_last; then a clean frame 10..17
        for (int i = 1; i <= 7; i++)
            tbl.push_back(mk(1, W'(i), 0, 0, 0, 1, 3'(i), 0, 32'd1, 32'd0));
        tbl.push_back(mk(1, 32'd8, 1, 0, 1, 0, 3'd0, 0, 32'd1, 32'd8));
        tbl.push_back(mk(0, 32'd0, 0, 1, 0, 1, 3'd0, 0, 32'd1, 32'd8));
        tbl.push_back(mk(1, 32'd100, 0, 0, 0, 1, 3'd1, 0, 32'd100, 32'd8));
        tbl.push_back(mk(1, 32'd101, 0, 0, 0, 1, 3'd2, 0, 32'd100, 32'd8));
        tbl.push_back(mk(1, 32'd102, 1, 0, 0, 1, 3'd0, 1, 32'd100, 32'd8));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(1, W'(10 + i), 0, 0, 0, 1, 3'(i + 1), 1, 32'd10, 32'd8));
        tbl.push_back(mk(1, 32'd17, 1, 0, 1, 0, 3'd0, 1, 32'd10, 32'd17));
        tbl.push_back(mk(0, 32'd0, 0, 0, 1, 0, 3'd0, 1, 32'd10, 32'd17));
        tbl.push_back(mk(0, 32'd0, 0, 1, 0, 1, 3'd0, 1, 32'd10, 32'd17));

        do_reset();
        foreach (tbl[k]) begin
            step(tbl[k].v, tbl[k].d, tbl[k].l, tbl[k].r, 0);
            chk($sformatf("tbl%0d_valid", k), op_valid, tbl[k].e_valid);
            chk($sformatf("tbl%0d_ready", k), in_ready, tbl[k].e_ready);
            chk($sformatf("tbl%0d_cnt", k), load_cnt, tbl[k].e_cnt);
            chk($sformatf("tbl%0d_err", k), frame_err, tbl[k].e_err);
            chk($sformatf("tbl%0d_X", k), X, tbl[k].e_x);
            chk($sformatf("tbl%0d_T", k), T, tbl[k].e_t);
        end

        // Held set with in_valid high: nothing consumed until handoff
        do_reset();
        for (int i = 0; i < 8; i++) step(1, W'(50 + i), i == 7, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 32'hAA, 0, 0, 0);
            chk("hold_valid", op_valid, 1'b1);
            chk("hold_ready", in_ready, 1'b0);
            chk("hold_X", X, 32'd50);
            chk("hold_T", T, 32'd57);
        end
        step(1, 32'hAA, 0, 1, 0);
        chk("accept_valid", op_valid, 1'b0);
        chk("accept_ready", in_ready, 1'b1);
        step(1, 32'hAA, 0, 0, 0);
        chk("aa_X", X, 32'hAA);
        chk("aa_cnt", load_cnt, 3'd1);

        // Eight words without in_last: error but still presented; clearing variant
        do_reset();
        for (int i = 0; i < 8; i++) step(1, W'(30 + i), 0, 0, 0);
        chk("nolast_valid", op_valid, 1'b1);
        chk("nolast_err", frame_err, 1'b1);
        chk("nolast_cT", cT, 32'd37);
        step(0, 0, 0, 1, 0);
        chk("clr_cX", cX, 32'd0);
        chk("clr_cT", cT, 32'd0);
        chk("noclr_T", T, 32'd37);

`ifdef OPLOAD_ABORT_EN
        do_reset();
        for (int i = 0; i < 4; i++) step(1, W'(40 + i), 0, 0, 0);
        step(1, 32'hEE, 0, 0, 1);
        chk("abort_cnt", load_cnt, 3'd0);
        chk("abort_err", frame_err, 1'b0);
        chk("abort_ready", in_ready, 1'b1);
        for (int i = 0; i < 8; i++) step(1, W'(20 + i), i == 7, 0, 0);
        chk("abort_valid", op_valid, 1'b1);
        chk("abort_X", X, 32'd20);
        chk("abort_T", T, 32'd27);
`endif

        // Asynchronous reset in the middle of HOLD
        do_reset();
        for (int i = 0; i < 8; i++) step(1, W'(60 + i), i == 7, 0, 0);
        chk("pre_arst_valid", op_valid, 1'b1);
        #2;
        rst = 1;
        #1;
        chk("arst_valid", op_valid, 1'b0);
        chk("arst_ready", in_ready, 1'b1);
        chk("arst_X", X, 32'd0);
        chk("arst_T", T, 32'd0);
        chk("arst_cX", cX, 32'd0);
        #2;
        rst = 0;
        mdl_reset();
        in_valid = 0; op_ready = 0;
        @(posedge clk);
        #1;
        mdl_compare();

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            bit v, l, r, ab;
            v  = ($urandom_range(0, 9) < 7);
            l  = (partial.size() == 7) ^ ($urandom_range(0, 15) == 0);
            r  = $urandom_range(0, 1);
            ab = ($urandom_range(0, 19) == 0);
            step(v, $urandom, l, r, ab);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
